// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_busy, tx_done, tx_err
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_busy, tx_done, tx_err
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK check).
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         kbd_clk_in,
   input  logic         kbd_data_in,
   output logic         kbd_clk_oe,
   output logic         kbd_data_oe
);

   // One counter serves both the inhibit interval and the watchdog.
   localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StIdle, StInhibit, StReq, StStart, StBits, StAck, StWaitIdle
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] timer_q, timer_d;
   logic [8:0]      shift_q, shift_d;
   logic [3:0]      bit_q, bit_d;
   logic            ack_q, ack_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            kclk_meta_q, kclk_sync_q, kclk_prev_q;
   logic            kdat_meta_q, kdat_sync_q;
   logic            fall;

   assign fall = kclk_prev_q & ~kclk_sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kclk_meta_q <= 1'b1;
         kclk_sync_q <= 1'b1;
         kclk_prev_q <= 1'b1;
         kdat_meta_q <= 1'b1;
         kdat_sync_q <= 1'b1;
      end else begin
         kclk_meta_q <= kbd_clk_in;
         kclk_sync_q <= kclk_meta_q;
         kclk_prev_q <= kclk_sync_q;
         kdat_meta_q <= kbd_data_in;
         kdat_sync_q <= kdat_meta_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         timer_q <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      ack_d   = ack_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (tx.tx_valid) begin
               shift_d = {~^tx.tx_data, tx.tx_data};
               timer_d = '0;
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            if (timer_q == CntW'(INHIBIT_CYCLES - 1)) begin
               timer_d = '0;
               state_d = StReq;
            end else begin
               timer_d = timer_q + CntW'(1);
            end
         end
         StReq: state_d = StStart;
         StStart: begin
            if (fall) begin
               bit_d   = '0;
               state_d = StBits;
            end
         end
         StBits: begin
            // Edges 2..9 advance to bits 1..7 and parity; edge 10 releases data for the stop bit.
            if (fall) begin
               if (bit_q == 4'd8) begin
                  state_d = StAck;
               end else begin
                  shift_d = {1'b1, shift_q[8:1]};
                  bit_d   = bit_q + 4'd1;
               end
            end
         end
         StAck: begin
            if (fall) begin
               ack_d   = ~kdat_sync_q;
               err_d   = kdat_sync_q;
               state_d = StWaitIdle;
            end
         end
         StWaitIdle: begin
            if (kclk_sync_q && kdat_sync_q) begin
               done_d  = ack_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if (state_q inside {StReq, StStart, StBits, StAck}) begin
         timer_d = fall ? '0 : timer_q + CntW'(1);
         if (!fall && timer_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
         end
      end
`endif
   end

   // Line drives decode straight from state so reset releases the bus asynchronously.
   always_comb begin
      kbd_clk_oe  = (state_q == StInhibit) || (state_q == StReq);
      kbd_data_oe = (state_q == StReq) || (state_q == StStart) ||
                    ((state_q == StBits) && !shift_q[0]);
   end

   assign tx.tx_ready = (state_q == StIdle);
   assign tx.tx_busy  = (state_q != StIdle);
   assign tx.tx_done  = done_q;
   assign tx.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus plus a simple PS/2 device model.
module tb_ps2_host_tx;
   localparam int unsigned Inhibit = 20;
   localparam int unsigned Timeout = 400;
   localparam int          Half    = 10;

   typedef struct {
      logic [7:0]  data;
      bit          ack;
      bit          inject;
      logic [10:0] bits;
      int          done_n;
      int          err_n;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic kbd_clk_oe, kbd_data_oe;
   logic bus_clk, bus_data;

   int passed = 0;
   int total = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int inh_run = 0;
   int req_run = 0;
   int cyc = 0;
   int req_cyc = 0;
   int err_cyc = 0;

   ps2_host_tx_if bus ();

   assign bus_clk  = ~kbd_clk_oe & dev_clk;
   assign bus_data = ~kbd_data_oe & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES (Inhibit),
      .TIMEOUT_CYCLES (Timeout)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx          (bus),
      .kbd_clk_in  (bus_clk),
      .kbd_data_in (bus_data),
      .kbd_clk_oe  (kbd_clk_oe),
      .kbd_data_oe (kbd_data_oe)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.tx_done) done_cnt++;
      if (bus.tx_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (bus.tx_done && bus.tx_err) both_cnt++;
      if (kbd_clk_oe && !kbd_data_oe) inh_run++;
      if (kbd_clk_oe && kbd_data_oe) begin
         req_run++;
         req_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic send(input logic [7:0] d);
      int budget = 0;
      while (!bus.tx_ready && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      @(negedge clk);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      check("ready_low_after_accept", {31'd0, bus.tx_ready}, 32'd0);
      check("busy_after_accept", {31'd0, bus.tx_busy}, 32'd1);
   endtask

   // Device side: waits for request-to-send, then clocks n_edges falling edges,
   // sampling the data line just before each one; optionally ACKs at edge 11.
   task automatic device_frame(input bit ack, input int n_edges, output logic [10:0] bits);
      int budget = 0;
      bits = '0;
      while (!(kbd_clk_oe && kbd_data_oe) && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      while (kbd_clk_oe && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      check("device_saw_request", {31'd0, budget < 2000}, 32'd1);
      repeat (Half) @(posedge clk);
      for (int i = 0; i < n_edges; i++) begin
         @(negedge clk);
         bits[i] = bus_data;
         if (i == 10 && ack) begin
            dev_data = 1'b0;
            repeat (2) @(posedge clk);
         end
         dev_clk = 1'b0;
         repeat (Half) @(posedge clk);
         dev_clk = 1'b1;
         repeat (Half) @(posedge clk);
      end
      dev_data = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [10:0] got;
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      inh_run = 0;
      req_run = 0;
      send(v.data);
      fork
         device_frame(v.ack, 11, got);
         begin
            if (v.inject) begin
               repeat (60) @(posedge clk);
               @(negedge clk);
               bus.tx_data  = 8'h55;
               bus.tx_valid = 1'b1;
               @(negedge clk);
               bus.tx_valid = 1'b0;
            end
         end
      join
      repeat (12) @(posedge clk);
      @(negedge clk);
      check($sformatf("frame_bits_%02h", v.data), {21'd0, got}, {21'd0, v.bits});
      check("done_pulses", done_cnt - d0, v.done_n);
      check("err_pulses", err_cnt - e0, v.err_n);
      check("inhibit_len", inh_run, Inhibit);
      check("req_len", req_run, 1);
      check("ready_after", {31'd0, bus.tx_ready}, 32'd1);
      check("lines_released", {30'd0, kbd_clk_oe, kbd_data_oe}, 32'd0);
      if (v.inject) begin
         repeat (40) @(posedge clk);
         @(negedge clk);
         check("no_frame_from_ignored_req", {31'd0, kbd_clk_oe}, 32'd0);
         check("ignored_req_no_done", done_cnt - d0, 1);
      end
   endtask

   vec_t vecs[6];

   initial begin
      logic [10:0] part;
      int d0, e0;
      vec_t vf4;
      vecs[0] = '{8'hED, 1'b1, 1'b0, 11'b1_1_11101101_0, 1, 0};
      vecs[1] = '{8'h1C, 1'b1, 1'b0, 11'b1_0_00011100_0, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0, 1, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0, 1, 0};
      vecs[4] = '{8'hA5, 1'b0, 1'b0, 11'b1_1_10100101_0, 0, 1};
      vecs[5] = '{8'hED, 1'b1, 1'b1, 11'b1_1_11101101_0, 1, 0};
      vf4     = '{8'hF4, 1'b1, 1'b0, 11'b1_0_11110100_0, 1, 0};

      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
      check("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
      check("rst_done_err", {30'd0, bus.tx_done, bus.tx_err}, 32'd0);
      check("rst_oe", {30'd0, kbd_clk_oe, kbd_data_oe}, 32'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset after the 4th falling edge, then a clean follow-up frame.
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hED);
      device_frame(1'b1, 4, part);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("midframe_busy", {31'd0, bus.tx_busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("midframe_rst_oe", {30'd0, kbd_clk_oe, kbd_data_oe}, 32'd0);
      check("midframe_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
      repeat (3) @(posedge clk);
      check("midframe_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      run_vec(vf4);

`ifdef PS2_HOST_TX_TIMEOUT_EN
      begin
         int budget = 0;
         e0 = err_cnt;
         send(8'h12);
         while (err_cnt == e0 && budget < 2000) begin
            @(posedge clk);
            budget++;
         end
         @(negedge clk);
         check("timeout_err_seen", err_cnt - e0, 1);
         check("timeout_latency", err_cyc - req_cyc, Timeout);
         check("timeout_lines", {30'd0, kbd_clk_oe, kbd_data_oe}, 32'd0);
         check("timeout_idle", {31'd0, bus.tx_ready}, 32'd1);
      end
`endif

      check("done_err_never_together", both_cnt, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit length in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, watchdog limit in clk cycles (15 ms at 50 MHz).
REQ-003 SHALL have port clk  in  1  single system clock; all flops on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_data  in  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  in  1  request; accepted only when tx_valid and tx_ready are both 1.
REQ-007 SHALL have port tx_ready  out  1  high only in IDLE.
REQ-008 SHALL have port tx_busy  out  1  high in every non-IDLE state; lets the keyboard receiver ignore the bus.
REQ-009 SHALL have port tx_done  out  1  one-cycle pulse on acknowledged completion.
REQ-010 SHALL have port tx_err  out  1  one-cycle pulse on NACK or timeout.
REQ-011 SHALL have port kbd_clk_in  in  1  PS/2 clock line, asynchronous.
REQ-012 SHALL have port kbd_data_in  in  1  PS/2 data line, asynchronous.
REQ-013 SHALL have port kbd_clk_oe  out  1  1 = pull clock line low (open drain).
REQ-014 SHALL have port kbd_data_oe  out  1  1 = pull data line low (open drain).

Function
REQ-015 SHALL pass kbd_clk_in and kbd_data_in through 2-flop synchronizers; a falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, START, BITS, ACK, WAIT_IDLE.
REQ-017 On acceptance, SHALL latch tx_data, compute odd parity (parity = ~^tx_data) and enter INHIBIT next cycle.
REQ-018 INHIBIT: kbd_clk_oe=1, kbd_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: kbd_clk_oe=1, kbd_data_oe=1 for exactly 1 cycle, then START.
REQ-020 START: kbd_clk_oe=0, kbd_data_oe=1 (start bit 0); on 1st falling edge, enter BITS.
REQ-021 BITS: falling edges 1..8 SHALL present data bits 0..7 LSB first, edge 9 parity, edge 10 stop (line released); kbd_data_oe = inverse of bit value, updated the cycle after the edge is detected.
REQ-022 On the 11th falling edge, SHALL sample synced data: 0 = ACK -> WAIT_IDLE; 1 = NACK -> tx_err pulse, then WAIT_IDLE.
REQ-023 WAIT_IDLE: both lines released; when synced clock and data are both 1, tx_done pulses (ACK case only) and the block returns to IDLE.
REQ-024 tx_valid asserted while tx_ready=0 SHALL be ignored; tx_data is not re-sampled mid-frame.
REQ-025 tx_done and tx_err SHALL never pulse in the same cycle.

Reset
REQ-026 While reset=0: state IDLE, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0, kbd_clk_oe=0, kbd_data_oe=0, counters and synchronizers cleared (synchronizers to 1).
REQ-027 Reset asserted mid-frame SHALL release both lines immediately, without a tx_done or tx_err pulse.

Configuration
REQ-028 Macro PS2_HOST_TX_TIMEOUT_EN defined: a counter SHALL run from leaving INHIBIT until entering WAIT_IDLE, restart at each falling edge, and on reaching TIMEOUT_CYCLES release both lines, pulse tx_err and go to IDLE.
REQ-029 Macro undefined: no watchdog logic; the block waits on clock edges indefinitely.

Verification
REQ-030 Send 0xED, device model clocks and ACKs -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulse once; tx_ready=1 afterwards.
REQ-031 Send 0x1C -> parity 0; send 0xFF -> parity 1; send 0x00 -> parity 1; each tx_done.
REQ-032 Device leaves data high at the 11th edge -> tx_err pulse, no tx_done, lines released.
REQ-033 PS2_HOST_TX_TIMEOUT_EN defined, device never clocks -> tx_err exactly TIMEOUT_CYCLES cycles after REQ, lines released, IDLE.
REQ-034 Assert reset=0 after the 4th falling edge -> both oe outputs 0 the same cycle, tx_ready=1; a subsequent 0xF4 completes with tx_done.
REQ-035 Pulse tx_valid with 0x55 during an 0xED frame -> ignored; only 0xED bits appear on the bus.
